mul_issue_queue: RTL

- Operand buffer and sequencer directly upstream of the iterative 64-bit multiplier.
- Accepts tagged multiply requests from the execute pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Issues requests to the multiplier one at a time with a single-cycle enable pulse, then waits for the multiplier's ready pulse.
- Returns each result with its tag over a valid/ready response handshake; a watchdog aborts any operation whose ready pulse never arrives.

---
 rtl/mul_issue_queue_pkg.sv | 16 +
 rtl/mul_issue_queue_if.sv | 45 ++++
 rtl/mul_req_fifo.sv | 60 ++++++
 rtl/mul_issue_queue.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mul_issue_queue_pkg.sv
// Shared types and widths for the multiplier issue queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mul_iq_state_t;

endpackage

// File: rtl/mul_issue_queue_if.sv
// Request / multiplier / response bundle between the execute pipe, the issue queue and the multiplier.
// Latency: n/a (wires only).
// Backpressure: req_ready_o and rsp_ready_i carry the valid/ready flow control.
// Modports: slave = issue queue side, master = pipeline + multiplier + consumer side.
interface mul_issue_queue_if #(
    parameter int DATA_WIDTH = mul_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = mul_pkg::TAG_WIDTH,
    parameter int CNT_WIDTH  = 3
);
    // request from execute
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [DATA_WIDTH-1:0] req_op_a_i;
    logic [DATA_WIDTH-1:0] req_op_b_i;
    logic [TAG_WIDTH-1:0]  req_tag_i;
    // multiplier side
    logic                  mul_enable_o;
    logic [DATA_WIDTH-1:0] mul_op_a_o;
    logic [DATA_WIDTH-1:0] mul_op_b_o;
    logic                  mul_ready_i;
    logic [DATA_WIDTH-1:0] mul_result_i;
    // response to consumer
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_result_o;
    logic [TAG_WIDTH-1:0]  rsp_tag_o;
    logic                  rsp_err_o;
    // status
    logic [CNT_WIDTH-1:0]  count_o;

    modport slave (
        input  req_valid_i, req_op_a_i, req_op_b_i, req_tag_i,
        input  mul_ready_i, mul_result_i, rsp_ready_i,
        output req_ready_o, mul_enable_o, mul_op_a_o, mul_op_b_o,
        output rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o, count_o
    );

    modport master (
        output req_valid_i, req_op_a_i, req_op_b_i, req_tag_i,
        output mul_ready_i, mul_result_i, rsp_ready_i,
        input  req_ready_o, mul_enable_o, mul_op_a_o, mul_op_b_o,
        input  rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o, count_o
    );

endinterface

// File: rtl/mul_req_fifo.sv
// Synchronous FIFO holding pending multiply requests; head entry is shown combinationally on o_dat.
// Latency: one cycle from push to visibility at the head (no bypass).
// Backpressure: pushes are dropped while full, pops ignored while empty; o_full drives upstream ready.
// Ports: clk_i/rsn_i, i_push/i_dat, i_pop, o_dat (head), o_full, o_empty, o_count.
module mul_req_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the count so pointer equality never needs disambiguating.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mul_issue_queue.sv
// Buffers tagged multiply requests and sequences them one at a time into the iterative multiplier.
// Latency: accept at edge N -> enable in cycle N+1 -> (ready in N+2) -> response valid in cycle N+3.
// Backpressure: req_ready_o = !full; a held response (rsp_ready_i=0) blocks further issues.
// Ports: clk_i, rsn_i (async active-low), bus (slave modport: req_*, mul_*, rsp_*, count_o).
module mul_issue_queue #(
    parameter int DATA_WIDTH     = mul_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH      = mul_pkg::TAG_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    mul_issue_queue_if.slave  bus
);
    import mul_pkg::*;

    localparam int ENTRY_W = TAG_WIDTH + 2 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int WDOG_W  = $clog2(TIMEOUT_CYCLES + 1);

    mul_iq_state_t         r_state;
    mul_iq_state_t         w_state_nxt;
    logic [WDOG_W-1:0]     r_wdog;
    logic [WDOG_W-1:0]     w_wdog_nxt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [ENTRY_W-1:0]    w_push_dat;
    logic [ENTRY_W-1:0]    w_head_dat;
    logic [DATA_WIDTH-1:0] w_head_a;
    logic [DATA_WIDTH-1:0] w_head_b;
    logic [TAG_WIDTH-1:0]  w_head_tag;

    logic                  w_mul_enable;
    logic                  w_capture;
    logic                  w_abort;
    logic                  w_rsp_done;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic                  r_rsp_err;

    // Entry layout: {tag, op_b, op_a}
    assign w_push_dat = {bus.req_tag_i, bus.req_op_b_i, bus.req_op_a_i};
    assign w_head_a   = w_head_dat[DATA_WIDTH-1:0];
    assign w_head_b   = w_head_dat[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_head_tag = w_head_dat[ENTRY_W-1:2*DATA_WIDTH];

    // A full FIFO refuses the push even when a pop lands on the same edge.
    assign w_push = bus.req_valid_i && !w_full;
    assign w_pop  = w_capture || w_abort;

    mul_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .i_push  (w_push),
        .i_dat   (w_push_dat),
        .i_pop   (w_pop),
        .o_dat   (w_head_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wdog_nxt   = r_wdog;
        w_mul_enable = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !r_rsp_valid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_mul_enable = 1'b1;
                w_wdog_nxt   = '0;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                // A ready pulse in the last allowed cycle still wins over the abort.
                w_wdog_nxt = r_wdog + WDOG_W'(1);
                if (bus.mul_ready_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_wdog_nxt == WDOG_W'(TIMEOUT_CYCLES)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_rsp_valid && bus.rsp_ready_i) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_wdog       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            if (w_capture || w_abort) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_capture ? bus.mul_result_i : '0;
                r_rsp_tag    <= w_head_tag;
                r_rsp_err    <= w_abort;
            end else if (w_rsp_done) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    // Head operands are stable from ISSUE until the pop because nothing else moves the read pointer.
    assign bus.mul_enable_o = w_mul_enable;
    assign bus.mul_op_a_o   = w_head_a;
    assign bus.mul_op_b_o   = w_head_b;
    assign bus.req_ready_o  = !w_full;
    assign bus.rsp_valid_o  = r_rsp_valid;
    assign bus.rsp_result_o = r_rsp_result;
    assign bus.rsp_tag_o    = r_rsp_tag;
    assign bus.rsp_err_o    = r_rsp_err;
    assign bus.count_o      = w_count;

endmodule
